// File: rtl/operand_loader.sv
// operand_loader: button-driven operand capture and decrypt launch FSM; define OPERAND_LOADER_DEBOUNCE_EN to debounce buttons
module operand_loader #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btnU,
  input  logic        btnC,
  input  logic        btnD,
  input  logic        dec_done,
  output logic [15:0] key_n,
  output logic [15:0] key_d,
  output logic [15:0] cipher,
  output logic        start,
  output logic [1:0]  slot,
  output logic        busy
);
  typedef enum logic [2:0] {LOAD_N, LOAD_D, LOAD_C, ARMED, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [2:0] btn, sync1, sync2, lvl, prev, seen_low, pulse;
  logic [1:0] warm;
  logic clr, load, go;
  assign btn = {btnD, btnC, btnU};
  always_ff @(posedge clk)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      seen_low <= '0;
      warm <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev <= lvl;
      seen_low <= seen_low | (warm == 2'd2 ? ~sync2 : 3'b000);
      warm <= warm == 2'd2 ? warm : warm + 2'd1;
    end
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [CW-1:0] cnt;
    logic deb;
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if (sync2[b] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt <= '0;
        deb <= sync2[b];
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign lvl[b] = deb;
  end
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign lvl = sync2;
`endif
  assign pulse = lvl & ~prev & seen_low;
  always_comb begin
    clr = pulse[2] && state != BUSY;
    load = pulse[0] && !clr && (state == LOAD_N || state == LOAD_D || state == LOAD_C);
    go = pulse[1] && !clr && (state == ARMED || state == DONE);
    nxt = clr ? LOAD_N : load ? state_t'(state + 3'd1) : go ? BUSY :
          (state == BUSY && dec_done) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= LOAD_N;
      key_n <= '0;
      key_d <= '0;
      cipher <= '0;
      start <= 1'b0;
    end else begin
      state <= nxt;
      start <= go;
      key_n <= clr ? '0 : (load && state == LOAD_N) ? sw : key_n;
      key_d <= clr ? '0 : (load && state == LOAD_D) ? sw : key_d;
      cipher <= clr ? '0 : (load && state == LOAD_C) ? sw : cipher;
    end
  assign busy = state == BUSY;
  assign slot = state > LOAD_C ? 2'd3 : state[1:0];
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: table-driven directed checks of operand_loader plus reset, latency and debounce sequences
module tb_operand_loader;
  localparam int DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int HOLD = 10;
  localparam int LAT = 3 + DB;
`else
  localparam int HOLD = 2;
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sw = '0;
  logic btnU = 1'b0, btnC = 1'b0, btnD = 1'b0, dec_done = 1'b0;
  logic [15:0] key_n, key_d, cipher;
  logic start, busy;
  logic [1:0] slot;
  int total = 0, bad = 0, nstart = 0;
  always #5 clk = ~clk;
  operand_loader #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btnU(btnU), .btnC(btnC), .btnD(btnD),
    .dec_done(dec_done), .key_n(key_n), .key_d(key_d), .cipher(cipher),
    .start(start), .slot(slot), .busy(busy)
  );
  typedef struct {
    logic [2:0] btn;
    int hold;
    logic [15:0] sw;
    logic done;
    logic [15:0] en, ed, ec;
    logic [1:0] es;
    logic eb;
    int est;
  } vec_t;
  vec_t v[17];
  always @(negedge clk)
    if (!rst && start) begin
      nstart++;
      total++;
      if (!busy) begin
        bad++;
        $display("FAIL busy_with_start: busy=%0d expected 1", busy);
      end
    end
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [2:0] b, input int h);
    {btnD, btnC, btnU} = b;
    tick(h);
    {btnD, btnC, btnU} = 3'b000;
    tick(12);
  endtask
  task automatic pulse_done;
    dec_done = 1'b1;
    tick(1);
    dec_done = 1'b0;
    tick(2);
  endtask
  task automatic check_ops(input string t, input int en, input int ed, input int ec, input int es, input int eb);
    check({t, " key_n"}, key_n, en);
    check({t, " key_d"}, key_d, ed);
    check({t, " cipher"}, cipher, ec);
    check({t, " slot"}, slot, es);
    check({t, " busy"}, busy, eb);
  endtask
  initial begin
    int st0;
    v[0]  = '{3'b001, 0, 16'd11, 1'b0, 16'd11, 16'd0, 16'd0, 2'd1, 1'b0, 0};
    v[1]  = '{3'b001, 0, 16'd3, 1'b0, 16'd11, 16'd3, 16'd0, 2'd2, 1'b0, 0};
    v[2]  = '{3'b001, 0, 16'd7, 1'b0, 16'd11, 16'd3, 16'd7, 2'd3, 1'b0, 0};
    v[3]  = '{3'b010, 50, 16'd0, 1'b0, 16'd11, 16'd3, 16'd7, 2'd3, 1'b1, 1};
    v[4]  = '{3'b101, 0, 16'hFFFF, 1'b0, 16'd11, 16'd3, 16'd7, 2'd3, 1'b1, 0};
    v[5]  = '{3'b000, 0, 16'd0, 1'b1, 16'd11, 16'd3, 16'd7, 2'd3, 1'b0, 0};
    v[6]  = '{3'b010, 50, 16'd0, 1'b0, 16'd11, 16'd3, 16'd7, 2'd3, 1'b1, 1};
    v[7]  = '{3'b000, 0, 16'd0, 1'b1, 16'd11, 16'd3, 16'd7, 2'd3, 1'b0, 0};
    v[8]  = '{3'b100, 0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b0, 0};
    v[9]  = '{3'b010, 0, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b0, 0};
    v[10] = '{3'b001, 0, 16'd9, 1'b0, 16'd9, 16'd0, 16'd0, 2'd1, 1'b0, 0};
    v[11] = '{3'b101, 0, 16'd5, 1'b0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b0, 0};
    v[12] = '{3'b001, 0, 16'd1, 1'b0, 16'd1, 16'd0, 16'd0, 2'd1, 1'b0, 0};
    v[13] = '{3'b001, 0, 16'd2, 1'b0, 16'd1, 16'd2, 16'd0, 2'd2, 1'b0, 0};
    v[14] = '{3'b011, 0, 16'd4, 1'b0, 16'd1, 16'd2, 16'd4, 2'd3, 1'b0, 0};
    v[15] = '{3'b010, 0, 16'd0, 1'b1, 16'd1, 16'd2, 16'd4, 2'd3, 1'b0, 1};
    v[16] = '{3'b010, 0, 16'd0, 1'b0, 16'd1, 16'd2, 16'd4, 2'd3, 1'b1, 1};
    tick(3);
    check_ops("reset", 0, 0, 0, 0, 0);
    check("reset start", start, 0);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 17; i++) begin
      st0 = nstart;
      sw = v[i].sw;
      if (v[i].btn != 3'b000) press(v[i].btn, v[i].hold != 0 ? v[i].hold : HOLD);
      if (v[i].done) pulse_done();
      check_ops($sformatf("v%0d", i), v[i].en, v[i].ed, v[i].ec, v[i].es, v[i].eb);
      check($sformatf("v%0d starts", i), nstart - st0, v[i].est);
    end
    st0 = nstart;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    pulse_done();
    check_ops("rst_busy", 0, 0, 0, 0, 0);
    check("rst_busy starts", nstart - st0, 0);
    sw = 16'h0055;
    btnU = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check_ops("held_rst", 0, 0, 0, 0, 0);
    btnU = 1'b0;
    tick(12);
    sw = 16'h1234;
    btnU = 1'b1;
    tick(LAT - 1);
    check("lat early slot", slot, 0);
    tick(1);
    check("lat slot", slot, 1);
    check("lat key_n", key_n, 16'h1234);
    btnU = 1'b0;
    tick(12);
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    sw = 16'h0077;
    btnU = 1'b1;
    tick(2);
    btnU = 1'b0;
    tick(20);
    check_ops("glitch", 16'h1234, 0, 0, 1, 0);
    press(3'b001, 10);
    check_ops("db_hold", 16'h1234, 16'h0077, 0, 2, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
